// File: rtl/cpu_types.sv
// Shared OTTER back-end types: RS tags, CDB broadcast struct and requester-to-tag mapping.
package cpu_types;

    typedef enum logic [2:0] {
        INVALID = 3'd0,
        STORE_1 = 3'd1,
        STORE_2 = 3'd2,
        LOAD_1  = 3'd3,
        LOAD_2  = 3'd4,
        ALU_1   = 3'd5,
        ALU_2   = 3'd6
    } RS_tag_type;

    localparam int unsigned NUM_REQ    = 6;
    localparam int unsigned PTR_W      = 3;
    localparam int unsigned CDB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        RS_tag_type            tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_t;

    // Requester index order matches the dispatch busy vector.
    function automatic RS_tag_type req_to_tag(input logic [PTR_W-1:0] idx);
        case (idx)
            3'd0:    return STORE_1;
            3'd1:    return STORE_2;
            3'd2:    return LOAD_1;
            3'd3:    return LOAD_2;
            3'd4:    return ALU_1;
            3'd5:    return ALU_2;
            default: return INVALID;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr (wrapping) wins.
module rr_pick #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    int unsigned j;
    logic        found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            // Shifts instead of variable bit-selects keep index widths clean.
            if (!found && |(req & (NUM_REQ'(1) << j))) begin
                found = 1'b1;
                gnt   = NUM_REQ'(1) << j;
                idx   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one RS result per cycle onto the shared bus.
// Define CDB_RR_EN for round-robin priority; otherwise lowest index wins.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = cpu_types::NUM_REQ,
    parameter int unsigned DATA_W  = cpu_types::CDB_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
    input  logic                      HOLD,
    input  logic                      FLUSH,
    output logic [NUM_REQ-1:0]        GNT,
    output logic                      CDB_VALID,
    output cpu_types::RS_tag_type     CDB_TAG,
    output logic [DATA_W-1:0]         CDB_DATA
);

    import cpu_types::*;

    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               grant_en;
    logic               any_gnt;

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= '0;
        end else if (FLUSH) begin
            ptr_q <= '0;
        end else if (any_gnt) begin
            ptr_q <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req (REQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Reset gates the grant so no requester sees a handshake it cannot complete.
    assign grant_en = RST_N && !HOLD && !FLUSH;
    assign GNT      = grant_en ? pick_gnt : '0;
    assign any_gnt  = |GNT;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CDB_VALID <= 1'b0;
            CDB_TAG   <= INVALID;
            CDB_DATA  <= '0;
        end else if (any_gnt) begin
            CDB_VALID <= 1'b1;
            CDB_TAG   <= req_to_tag(pick_idx);
            CDB_DATA  <= DATA_W'(REQ_DATA >> (32'(pick_idx) * DATA_W));
        end else begin
            CDB_VALID <= 1'b0;
            CDB_TAG   <= INVALID;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors, expectations queued, monitor compares.
module tb_cdb_arbiter;
    import cpu_types::*;

    localparam int unsigned N  = 6;
    localparam int unsigned DW = 32;

    logic              CLK      = 1'b0;
    logic              RST_N    = 1'b0;
    logic [N-1:0]      REQ      = '1;
    logic [N*DW-1:0]   REQ_DATA = '0;
    logic              HOLD     = 1'b0;
    logic              FLUSH    = 1'b0;
    logic [N-1:0]      GNT;
    logic              CDB_VALID;
    RS_tag_type        CDB_TAG;
    logic [DW-1:0]     CDB_DATA;

    cdb_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .HOLD      (HOLD),
        .FLUSH     (FLUSH),
        .GNT       (GNT),
        .CDB_VALID (CDB_VALID),
        .CDB_TAG   (CDB_TAG),
        .CDB_DATA  (CDB_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic [5:0] req;
        logic       hold;
        logic       flush;
        logic       beef;
        logic [5:0] gnt_rr;
        logic [5:0] gnt_fp;
    } vec_t;

    typedef struct {
        int         v;
        logic [5:0] gnt;
    } gnt_exp_t;

    typedef struct {
        int          v;
        logic        valid;
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_exp_t;

    vec_t       vecs[$];
    gnt_exp_t   exp_gnt_q[$];
    cdb_exp_t   exp_cdb_q[$];
    RS_tag_type tag_tbl[6] = '{STORE_1, STORE_2, LOAD_1, LOAD_2, ALU_1, ALU_2};
    logic [31:0] last_data = '0;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic add(input logic r, input logic [5:0] q, input logic h, input logic f,
                       input logic b, input logic [5:0] grr, input logic [5:0] gfp);
        vec_t e;
        e.rst_n = r; e.req = q; e.hold = h; e.flush = f; e.beef = b;
        e.gnt_rr = grr; e.gnt_fp = gfp;
        vecs.push_back(e);
    endtask

    function automatic logic [31:0] slice_data(input int v, input int i, input logic b);
        if (b && i == 4) return 32'hDEADBEEF;
        return {8'hA5, 8'(v), 8'h00, 8'(i)};
    endfunction

    function automatic int onehot_idx(input logic [5:0] g);
        for (int i = 0; i < 6; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic apply(input int k);
        gnt_exp_t g;
        cdb_exp_t c;
        cdb_exp_t old;
        RST_N = vecs[k].rst_n;
        REQ   = vecs[k].req;
        HOLD  = vecs[k].hold;
        FLUSH = vecs[k].flush;
        for (int i = 0; i < 6; i++) REQ_DATA[i*DW +: DW] = slice_data(k, i, vecs[k].beef);
`ifdef CDB_RR_EN
        g.gnt = vecs[k].gnt_rr;
`else
        g.gnt = vecs[k].gnt_fp;
`endif
        g.v = k;
        // Asynchronous reset clears the bus before the next edge.
        if (!vecs[k].rst_n && exp_cdb_q.size() > 0) begin
            old = exp_cdb_q.pop_back();
            old.valid = 1'b0; old.tag = INVALID; old.data = '0;
            exp_cdb_q.push_back(old);
        end
        exp_gnt_q.push_back(g);
        c.v = k;
        if (!vecs[k].rst_n) begin
            last_data = '0;
            c.valid = 1'b0; c.tag = INVALID;
        end else if (g.gnt != 0) begin
            last_data = slice_data(k, onehot_idx(g.gnt), vecs[k].beef);
            c.valid = 1'b1; c.tag = tag_tbl[onehot_idx(g.gnt)];
        end else begin
            c.valid = 1'b0; c.tag = INVALID;
        end
        c.data = last_data;
        exp_cdb_q.push_back(c);
    endtask

    // Monitor: GNT checked in its own cycle, CDB one cycle after its vector.
    initial begin
        gnt_exp_t g;
        cdb_exp_t c;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_gnt_q.size() > 0) begin
                g = exp_gnt_q.pop_front();
                n_cmp++;
                if (GNT !== g.gnt) begin
                    n_fail++;
                    $display("FAIL gnt v%0d: got %b want %b", g.v, GNT, g.gnt);
                end
            end
            if (exp_cdb_q.size() > 1) begin
                c = exp_cdb_q.pop_front();
                n_cmp++;
                if (CDB_VALID !== c.valid || CDB_TAG !== c.tag || CDB_DATA !== c.data) begin
                    n_fail++;
                    $display("FAIL cdb v%0d: got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                             c.v, CDB_VALID, CDB_TAG, CDB_DATA, c.valid, c.tag, c.data);
                end
            end
        end
    end

    initial begin
        //  rst  req        hold flush beef  rr gnt     fixed gnt
        add(0, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000);
        add(0, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b111111, 0, 0, 0, 6'b000001, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b000010, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b000100, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b001000, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b010000, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b100000, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b000001, 6'b000001);
        add(1, 6'b111111, 0, 0, 0, 6'b000010, 6'b000001);
        add(1, 6'b010000, 0, 0, 1, 6'b010000, 6'b010000);
        add(1, 6'b100001, 0, 0, 0, 6'b100000, 6'b000001);
        add(1, 6'b100001, 0, 0, 0, 6'b000001, 6'b000001);
        add(1, 6'b100001, 0, 0, 0, 6'b100000, 6'b000001);
        add(1, 6'b000100, 1, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b000100, 1, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b000100, 1, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b000100, 0, 0, 0, 6'b000100, 6'b000100);
        add(1, 6'b001000, 1, 1, 0, 6'b000000, 6'b000000);
        add(1, 6'b100001, 0, 0, 0, 6'b000001, 6'b000001);
        add(1, 6'b111111, 0, 1, 0, 6'b000000, 6'b000000);
        add(1, 6'b000110, 0, 0, 0, 6'b000010, 6'b000010);
        add(1, 6'b000110, 0, 0, 0, 6'b000100, 6'b000010);
        add(1, 6'b111111, 1, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b111111, 0, 0, 0, 6'b001000, 6'b000001);
        add(0, 6'b111111, 0, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b111000, 0, 0, 0, 6'b001000, 6'b001000);
        add(1, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b100000, 0, 0, 0, 6'b100000, 6'b100000);
        add(1, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000);
        add(1, 6'b000000, 0, 0, 0, 6'b000000, 6'b000000);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge CLK);
            apply(k);
        end
        repeat (3) @(negedge CLK);
        #4;
        n_cmp++;
        if (exp_gnt_q.size() != 0 || exp_cdb_q.size() != 1) begin
            n_fail++;
            $display("FAIL drain: got gnt_q=%0d cdb_q=%0d want 0 and 1",
                     exp_gnt_q.size(), exp_cdb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
